// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bus plus the decode hand-off and redirect inputs.
interface fetch_prefetch_queue_if #(parameter int XLEN = 32);
  import fetch_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [XLEN-1:0]    dec_pc;
  logic               dec_ready;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} pairs; clear empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; a slot is only observed once count marks it valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: credit-limited in-order requests, response tagging, redirect flush.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                    clk,
  input logic                    reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            req, fire, rsp, push, pop, head_valid;
  entry_t          head, push_data;
  logic [1:0]      unused_redirect_lsb;

  assign unused_redirect_lsb = bus.redirect_pc[1:0];

  // Discarded responses are still outstanding, so they keep consuming credit.
  assign credit_used = {1'b0, count} + {1'b0, outstanding_q};
  assign req         = !reset && !bus.redirect_valid && (credit_used < DEPTH_W);
  assign fire        = req && bus.imem_gnt;
  assign rsp         = bus.imem_rvalid && (outstanding_q != '0);
  assign head_valid  = (count != '0);
  assign pop         = head_valid && bus.dec_ready;
  assign push_data   = '{pc: resp_pc_q, instr: bus.imem_rdata};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    push          = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      resp_pc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
      outstanding_d = outstanding_q - CW'(rsp);
      // Every response still in flight is stale: pending discards plus the rest.
      discard_d     = outstanding_q - CW'(rsp);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);
      if (rsp) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (bus.redirect_valid),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.dec_valid = head_valid;
  assign bus.dec_instr = head_valid ? head.instr : NOP_INSTR;
  assign bus.dec_pc    = head_valid ? head.pc : '0;
endmodule
